// File: rtl/snn_input_loader.sv
// snn_input_loader: streams a binary image into the SNN input RAM,
// starts the core and reports the digit. Option: SNN_LOADER_TIMEOUT_EN.
module snn_input_loader #(
   parameter int NUM_BITS    = 784,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_d,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   output logic [3:0]        result_digit,
   output logic              result_vld,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      S_LOAD,
      S_SHIFT,
      S_START,
      S_WAIT,
      S_REPORT
   } state_t;

   state_t            r_state;
   logic [7:0]        r_shift;
   logic [7:0]        r_hold;
   logic              r_hold_vld;
   logic [2:0]        r_bit;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_digit;
   logic              r_busy;
   logic              r_overrun;

   logic w_last_bit;
   logic w_last_byte;
   logic w_frame_end;
   logic w_late_byte;

   assign w_last_bit  = (r_bit == 3'd7);
   // current byte is the final one of the frame; nothing may queue behind it
   assign w_last_byte = (r_addr >= ADDR_W'(NUM_BITS - 8));
   assign w_frame_end = (r_addr == ADDR_W'(NUM_BITS - 1));
   assign w_late_byte = rx_rdy && ((r_state == S_START) ||
                                   (r_state == S_WAIT)  ||
                                   (r_state == S_REPORT));

`ifdef SNN_LOADER_TIMEOUT_EN
   logic [31:0] r_wcnt;
   logic        r_timeout;
   assign timeout_err = r_timeout;
`else
   logic w_unused_to;
   assign w_unused_to = (TIMEOUT_CYC != 0);
   assign timeout_err = 1'b0;
`endif

   // loader FSM: byte intake, bit serialisation, core handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_LOAD;
         r_shift    <= '0;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_bit      <= '0;
         r_addr     <= '0;
         r_digit    <= '0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
         r_wcnt     <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_LOAD: begin
               if (rx_rdy) begin
                  r_shift <= rx_data;
                  r_bit   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_shift <= {1'b0, r_shift[7:1]};
               r_addr  <= r_addr + ADDR_W'(1);
               r_bit   <= r_bit + 3'd1;
               if (w_last_bit) begin
                  if (r_hold_vld) begin
                     r_shift    <= r_hold;
                     r_hold_vld <= 1'b0;
                  end else if (rx_rdy && !w_last_byte) begin
                     r_shift <= rx_data;
                  end else if (w_frame_end) begin
                     r_state <= S_START;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
               if (rx_rdy) begin
                  if (w_last_byte || r_hold_vld) begin
                     r_overrun <= 1'b1;
                  end else if (!w_last_bit) begin
                     r_hold     <= rx_data;
                     r_hold_vld <= 1'b1;
                  end
               end
            end
            S_START: begin
               r_addr  <= '0;
               r_state <= S_WAIT;
`ifdef SNN_LOADER_TIMEOUT_EN
               r_wcnt  <= '0;
`endif
            end
            S_WAIT: begin
               if (core_done) begin
                  r_digit <= core_digit;
                  r_busy  <= 1'b0;
                  r_state <= S_REPORT;
`ifdef SNN_LOADER_TIMEOUT_EN
               end else if (r_wcnt == 32'(TIMEOUT_CYC - 1)) begin
                  r_timeout <= 1'b1;
                  r_digit   <= 4'hF;
                  r_busy    <= 1'b0;
                  r_state   <= S_REPORT;
               end else begin
                  r_wcnt <= r_wcnt + 32'd1;
`endif
               end
            end
            S_REPORT: begin
               r_state <= S_LOAD;
            end
            default: begin
               r_state <= S_LOAD;
            end
         endcase
         if (w_late_byte) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign ram_we       = (r_state == S_SHIFT);
   assign ram_addr     = r_addr;
   assign ram_d        = r_shift[0];
   assign core_start   = (r_state == S_START);
   assign result_vld   = (r_state == S_REPORT);
   assign result_digit = r_digit;
   assign busy         = r_busy;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_snn_input_loader.sv
// tb_snn_input_loader: directed bench for snn_input_loader.
// Timeout checks are active when SNN_LOADER_TIMEOUT_EN is defined.
module tb_snn_input_loader;

   localparam int NB = 784;
   localparam int AW = 10;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_rdy = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic          ram_d;
   logic          core_start;
   logic          core_done = 1'b0;
   logic [3:0]    core_digit = '0;
   logic [3:0]    result_digit;
   logic          result_vld;
   logic          busy;
   logic          overrun;
   logic          timeout_err;

   snn_input_loader #(
      .NUM_BITS(NB), .ADDR_W(AW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_rdy(rx_rdy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d),
      .core_start(core_start), .core_done(core_done),
      .core_digit(core_digit),
      .result_digit(result_digit), .result_vld(result_vld),
      .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic mem [0:1023];
   int   nwr, nstart, nvld, nwr_at_start;
   int   first_wr_cyc, last_wr_cyc, first_wr_addr;
   int   wr783_cyc, start_cyc, vld_cyc;
   logic busy_at_vld;

   always @(posedge clk) cyc <= cyc + 1;

   // observe RAM writes and handshake strobes mid-cycle
   always @(negedge clk) begin
      if (ram_we) begin
         mem[ram_addr] = ram_d;
         if (nwr == 0) begin
            first_wr_cyc  = cyc;
            first_wr_addr = int'(ram_addr);
         end
         last_wr_cyc = cyc;
         if (ram_addr == AW'(NB - 1)) wr783_cyc = cyc;
         nwr++;
      end
      if (core_start) begin
         nstart++;
         start_cyc    = cyc;
         nwr_at_start = nwr;
      end
      if (result_vld) begin
         nvld++;
         vld_cyc     = cyc;
         busy_at_vld = busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      for (int i = 0; i < 1024; i++) mem[i] = 1'bx;
      nwr = 0; nstart = 0; nvld = 0; nwr_at_start = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; first_wr_addr = -1;
      wr783_cyc = -1; start_cyc = -1; vld_cyc = -1;
      busy_at_vld = 1'bx;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clr_mon();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b; rx_rdy = 1'b1;
      @(posedge clk);
      #1 rx_rdy = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int gap);
      for (int i = 0; i < NB / 8; i++) begin
         send_byte(b);
         repeat (gap) @(posedge clk);
      end
   endtask

   function automatic logic [15:0] lo16();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = mem[k];
      return v;
   endfunction

   task automatic wait_start(input int lim);
      int t0;
      t0 = cyc;
      while (nstart == 0 && (cyc - t0) < lim) @(posedge clk);
      #1;
   endtask

   task automatic wait_vld(input int lim);
      int t0;
      t0 = cyc;
      while (nvld == 0 && (cyc - t0) < lim) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;
      int         errs;

      // reset state
      do_reset();
      chk("rst_outs", {ram_we, core_start, result_vld, busy,
                       overrun, timeout_err, result_digit}, 0);
      chk("rst_addr", ram_addr, 0);

      // back-to-back FF then 00
      @(posedge clk);
      #1 rx_data = 8'hFF; rx_rdy = 1'b1;
      @(posedge clk);
      #1 rx_data = 8'h00;
      @(posedge clk);
      #1 rx_rdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("b2b_data", lo16(), 16'h00FF);
      chk("b2b_nwr", nwr, 16);
      chk("b2b_contig", last_wr_cyc - first_wr_cyc, 15);
      chk("b2b_first_addr", first_wr_addr, 0);
      chk("b2b_ovr", overrun, 0);
      chk("b2b_busy", busy, 1);

      // three consecutive strobes: third dropped
      do_reset();
      @(posedge clk);
      #1 rx_data = 8'h0F; rx_rdy = 1'b1;
      @(posedge clk);
      #1 rx_data = 8'h3C;
      @(posedge clk);
      #1 rx_data = 8'hAA;
      @(posedge clk);
      #1 rx_rdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("drop_data", lo16(), 16'h3C0F);
      chk("drop_nwr", nwr, 16);
      chk("drop_ovr", overrun, 1);

      // continue to 40 bytes, then abort with reset
      for (int i = 0; i < 38; i++) begin
         send_byte(8'h5A);
         repeat (10) @(posedge clk);
      end
      do_reset();
      chk("abort_ovr_clr", overrun, 0);
      chk("abort_busy_clr", busy, 0);

      // full frame of A5 with 20-cycle gaps
      send_frame(8'hA5, 20);
      wait_start(50);
      chk("frm_nstart", nstart, 1);
      chk("frm_first_addr", first_wr_addr, 0);
      chk("frm_nwr_at_start", nwr_at_start, NB);
      chk("frm_start_lat", start_cyc - wr783_cyc, 1);
      chk("frm_a0", mem[0], 1);
      chk("frm_a1", mem[1], 0);
      chk("frm_a2", mem[2], 1);
      chk("frm_a7", mem[7], 1);
      chk("frm_a783", mem[783], 1);
      pat  = 8'hA5;
      errs = 0;
      for (int k = 0; k < NB; k++) if (mem[k] !== pat[k % 8]) errs++;
      chk("frm_pattern_errs", errs, 0);
      chk("frm_ovr", overrun, 0);

      // extra byte while waiting for the core: dropped, flagged
      send_byte(8'hFF);
      repeat (12) @(posedge clk);
      #1;
      chk("late_nwr", nwr, NB);
      chk("late_ovr", overrun, 1);

      // core_done with digit 7, 50 cycles after start
      while ((cyc - start_cyc) < 50) @(posedge clk);
      #1 core_done = 1'b1; core_digit = 4'd7;
      @(posedge clk);
      #1 core_done = 1'b0; core_digit = 4'd0;
      wait_vld(20);
      repeat (5) @(posedge clk);
      #1;
      chk("res_digit", result_digit, 7);
      chk("res_nvld", nvld, 1);
      chk("res_busy_at_vld", busy_at_vld, 0);
      chk("res_busy_after", busy, 0);

      // core_done outside WAIT_DONE is ignored
      #1 core_done = 1'b1; core_digit = 4'd3;
      @(posedge clk);
      #1 core_done = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("stray_done_digit", result_digit, 7);
      chk("stray_done_nvld", nvld, 1);

`ifdef SNN_LOADER_TIMEOUT_EN
      // watchdog path
      do_reset();
      send_frame(8'h33, 10);
      wait_start(50);
      chk("to_nstart", nstart, 1);
      wait_vld(TO + 20);
      chk("to_lat", vld_cyc - start_cyc, TO + 1);
      chk("to_err", timeout_err, 1);
      chk("to_digit", result_digit, 4'hF);
      #1 core_done = 1'b1; core_digit = 4'd3;
      @(posedge clk);
      #1 core_done = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("to_late_digit", result_digit, 4'hF);
      chk("to_late_nvld", nvld, 1);
`else
      chk("to_tied0", timeout_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
